i2s_receiver: RTL

I2S_RECEIVER -- requirements
Module: i2s_receiver

---
 rtl/i2s_receiver.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/i2s_receiver.sv
// I2S receiver: recovers left/right audio words from a codec bit stream,
// oversampling bclk/lr/sdata with the 100 MHz system clock.
module i2s_receiver #(
  parameter int WORD_BITS = 24,
  parameter int SLOT_BITS = 32
) (
  input  logic                 clk_100,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 i2s_bclk,
  input  logic                 i2s_lr,
  input  logic                 i2s_sdata,
  output logic [WORD_BITS-1:0] left_sample,
  output logic [WORD_BITS-1:0] right_sample,
  output logic [15:0]          sample16,
  output logic                 new_sample,
  output logic                 frame_err
);

  localparam int               CNT_W    = $clog2(SLOT_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(WORD_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LEFT,
    LEFT,
    RIGHT
  } state_t;

  logic                 r_bclkMeta, r_bclkSync, r_bclkHist;
  logic                 r_lrMeta, r_lrSync;
  logic                 r_sdMeta, r_sdSync;
  logic                 r_lrPrev;
  state_t               r_state;
  logic [CNT_W-1:0]     r_bitCnt;
  logic [WORD_BITS-1:0] r_shift;
  logic [WORD_BITS-1:0] r_pendLeft;
  logic                 r_leftOk;
  logic [WORD_BITS-1:0] r_leftSample;
  logic [WORD_BITS-1:0] r_rightSample;
  logic                 r_newSample;
  logic                 r_frameErr;

  logic                 w_bitEdge;
  logic                 w_lrChange;
  state_t               w_stateNext;
  logic [CNT_W-1:0]     w_cntNext;
  logic                 w_shiftEn;
  logic                 w_holdLeft;
  logic                 w_leftOkNext;
  logic                 w_publish;
  logic                 w_err;

  assign w_bitEdge  = r_bclkSync & ~r_bclkHist;
  assign w_lrChange = r_lrSync ^ r_lrPrev;

  assign left_sample  = r_leftSample;
  assign right_sample = r_rightSample;
  assign sample16     = r_leftSample[WORD_BITS-1 -: 16];
  assign new_sample   = r_newSample;
  assign frame_err    = r_frameErr;

  // Two-flop synchronizers for the codec signals, plus a history flop on bclk for edge detection
  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      r_bclkMeta <= 1'b0;
      r_bclkSync <= 1'b0;
      r_bclkHist <= 1'b0;
      r_lrMeta   <= 1'b0;
      r_lrSync   <= 1'b0;
      r_sdMeta   <= 1'b0;
      r_sdSync   <= 1'b0;
    end else begin
      r_bclkMeta <= i2s_bclk;
      r_bclkSync <= r_bclkMeta;
      r_bclkHist <= r_bclkSync;
      r_lrMeta   <= i2s_lr;
      r_lrSync   <= r_lrMeta;
      r_sdMeta   <= i2s_sdata;
      r_sdSync   <= r_sdMeta;
    end
  end

  // State register
  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and slot bookkeeping; the data bit on an lr-change edge belongs to the old slot and is dropped
  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_bitCnt;
    w_shiftEn    = 1'b0;
    w_holdLeft   = 1'b0;
    w_leftOkNext = r_leftOk;
    w_publish    = 1'b0;
    w_err        = 1'b0;
    if (!enable) begin
      w_stateNext = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_stateNext = WAIT_LEFT;
        end
        WAIT_LEFT: begin
          if (w_bitEdge && w_lrChange && !r_lrSync) begin
            w_stateNext = LEFT;
            w_cntNext   = '0;
          end
        end
        LEFT, RIGHT: begin
          if (w_bitEdge) begin
            if (w_lrChange) begin
              w_cntNext   = '0;
              w_stateNext = r_lrSync ? RIGHT : LEFT;
              if (r_bitCnt < CNT_WORD) begin
                w_err        = 1'b1;
                w_leftOkNext = 1'b0;
              end else if (r_state == LEFT) begin
                w_holdLeft   = 1'b1;
                w_leftOkNext = 1'b1;
              end else begin
                w_publish    = r_leftOk;
                w_leftOkNext = 1'b0;
              end
            end else if (r_bitCnt == CNT_MAX) begin
              w_err        = 1'b1;
              w_stateNext  = WAIT_LEFT;
              w_leftOkNext = 1'b0;
            end else begin
              w_cntNext = r_bitCnt + CNT_ONE;
              w_shiftEn = (w_cntNext <= CNT_WORD);
            end
          end
        end
        default: begin
          w_stateNext = IDLE;
        end
      endcase
    end
  end

  // Datapath: shift register, pending left word, published samples and strobes
  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      r_lrPrev      <= 1'b0;
      r_bitCnt      <= '0;
      r_shift       <= '0;
      r_pendLeft    <= '0;
      r_leftOk      <= 1'b0;
      r_leftSample  <= '0;
      r_rightSample <= '0;
      r_newSample   <= 1'b0;
      r_frameErr    <= 1'b0;
    end else begin
      if (w_bitEdge) begin
        r_lrPrev <= r_lrSync;
      end
      r_bitCnt <= w_cntNext;
      r_leftOk <= w_leftOkNext;
      if (w_shiftEn) begin
        r_shift <= {r_shift[WORD_BITS-2:0], r_sdSync};
      end
      if (w_holdLeft) begin
        r_pendLeft <= r_shift;
      end
      if (w_publish) begin
        r_leftSample  <= r_pendLeft;
        r_rightSample <= r_shift;
      end
      r_newSample <= w_publish;
      r_frameErr  <= w_err;
    end
  end

endmodule
